// File: rtl/data_mem_wbuf.sv
`timescale 1ns/1ps
// Posted-write buffer in front of data_mem: stores queue without stalling,
// loads wait for every older store to complete, then issue a single read.
module data_mem_wbuf #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              addr,
   input  logic [31:0]              write_data,
   input  logic                     memwrite,
   input  logic                     memread,
   input  logic [3:0]               sign_mask,
   output logic [31:0]              read_data,
   output logic                     clk_stall,
   output logic [$clog2(DEPTH):0]   wbuf_count,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_write_data,
   output logic [3:0]               mem_sign_mask,
   output logic                     mem_memwrite,
   output logic                     mem_memread,
   input  logic [31:0]              mem_read_data,
   input  logic                     mem_clk_stall
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } wb_entry_t;

   typedef enum logic [1:0] {
      F_IDLE,
      F_LOAD,
      F_SFULL
   } f_state_t;

   typedef enum logic [1:0] {
      B_INIT,
      B_IDLE,
      B_ISSUE,
      B_WAIT
   } b_state_t;

   f_state_t  f_state, f_next;
   b_state_t  b_state, b_next;

   wb_entry_t fifo_q [DEPTH];
   wb_entry_t hold_q;
   wb_entry_t cpu_entry;
   wb_entry_t push_entry;
   wb_entry_t head;

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   ld_addr;
   logic [3:0]    ld_mask;
   logic          acc_rd;
   logic          init_zero;

   logic full, empty;
   logic push, pop;
   logic b_done, disp_ok;
   logic rd_go, load_done;

   assign full      = (wbuf_count == CW'(DEPTH));
   assign empty     = (wbuf_count == '0);
   assign cpu_entry = {addr, write_data, sign_mask};
   assign head      = fifo_q[rd_ptr];

   // Back side: a completing read must not re-dispatch the same load.
   always_comb begin
      b_done    = (b_state == B_WAIT) && !mem_clk_stall;
      disp_ok   = (b_state == B_IDLE) || b_done;
      load_done = b_done && acc_rd;
      pop       = disp_ok && !empty;
      rd_go     = disp_ok && empty
                  && (f_state == F_LOAD) && !load_done;
      b_next    = b_state;
      unique case (b_state)
         B_INIT:  if (!mem_clk_stall && init_zero) b_next = B_IDLE;
         B_IDLE:  if (pop || rd_go) b_next = B_ISSUE;
         B_ISSUE: b_next = B_WAIT;
         B_WAIT: begin
            if (b_done) b_next = (pop || rd_go) ? B_ISSUE : B_IDLE;
         end
         default: b_next = B_INIT;
      endcase
   end

   always_comb begin
      push       = 1'b0;
      push_entry = cpu_entry;
      f_next     = f_state;
      unique case (f_state)
         F_IDLE: begin
            if (memread) begin
               f_next = F_LOAD;
            end else if (memwrite) begin
               if (!full || pop) push = 1'b1;
               else f_next = F_SFULL;
            end
         end
         F_SFULL: begin
            push_entry = hold_q;
            if (pop) begin
               push   = 1'b1;
               f_next = F_IDLE;
            end
         end
         F_LOAD:  if (load_done) f_next = F_IDLE;
         default: f_next = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_state   <= F_IDLE;
         clk_stall <= 1'b0;
         read_data <= '0;
         ld_addr   <= '0;
         ld_mask   <= '0;
         hold_q    <= '0;
      end else begin
         f_state   <= f_next;
         clk_stall <= (f_next != F_IDLE);
         if (f_state == F_IDLE && memread) begin
            ld_addr <= addr;
            ld_mask <= sign_mask;
         end
         if (f_state == F_IDLE && f_next == F_SFULL)
            hold_q <= cpu_entry;
         if (f_state == F_LOAD && load_done)
            read_data <= mem_read_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wbuf_count <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= push_entry;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         wbuf_count <= wbuf_count
                       + {{PW{1'b0}}, push}
                       - {{PW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_state        <= B_INIT;
         init_zero      <= 1'b0;
         acc_rd         <= 1'b0;
         mem_memwrite   <= 1'b0;
         mem_memread    <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         mem_sign_mask  <= '0;
      end else begin
         b_state      <= b_next;
         init_zero    <= (b_state == B_INIT) && !mem_clk_stall;
         mem_memwrite <= pop;
         mem_memread  <= rd_go;
         if (pop) begin
            acc_rd         <= 1'b0;
            mem_addr       <= head.addr;
            mem_write_data <= head.data;
            mem_sign_mask  <= head.mask;
         end else if (rd_go) begin
            acc_rd        <= 1'b1;
            mem_addr      <= ld_addr;
            mem_sign_mask <= ld_mask;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_wbuf.sv
`timescale 1ns/1ps
// Scoreboard bench for data_mem_wbuf with a mock data_mem and
// a program-order reference memory.
module tb_data_mem_wbuf;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   addr = '0;
   logic [31:0]   write_data = '0;
   logic          memwrite = 1'b0;
   logic          memread = 1'b0;
   logic [3:0]    sign_mask = '0;
   logic [31:0]   read_data;
   logic          clk_stall;
   logic [CW-1:0] wbuf_count;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_write_data;
   logic [3:0]    mem_sign_mask;
   logic          mem_memwrite;
   logic          mem_memread;
   logic [31:0]   mem_read_data = '0;
   logic          mem_clk_stall;

   data_mem_wbuf #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .addr(addr),
      .write_data(write_data),
      .memwrite(memwrite),
      .memread(memread),
      .sign_mask(sign_mask),
      .read_data(read_data),
      .clk_stall(clk_stall),
      .wbuf_count(wbuf_count),
      .mem_addr(mem_addr),
      .mem_write_data(mem_write_data),
      .mem_sign_mask(mem_sign_mask),
      .mem_memwrite(mem_memwrite),
      .mem_memread(mem_memread),
      .mem_read_data(mem_read_data),
      .mem_clk_stall(mem_clk_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
   } wr_t;

   wr_t         wr_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] rda_q[$];
   logic [3:0]  rdm_q[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] mock_mem [logic [31:0]];

   int   total = 0;
   int   bad = 0;
   int   lat = 2;
   int   busy = 0;
   int   peak = 0;
   logic preload = 1'b0;

   assign mem_clk_stall = preload || (busy != 0);

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 32'h0;
   endfunction

   function automatic logic [31:0] mock_rd(input logic [31:0] a);
      if (mock_mem.exists(a)) return mock_mem[a];
      return 32'h0;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Mock data_mem: each strobe stalls for lat cycles.
   initial forever begin
      @(posedge clk);
      if (mem_memwrite || mem_memread) begin
         busy <= lat;
         if (mem_memwrite) mock_mem[mem_addr] = mem_write_data;
         else mem_read_data <= mock_rd(mem_addr);
      end else if (busy != 0) begin
         busy <= busy - 1;
      end
   end

   // Monitor: pops expectations whenever the DUT presents something.
   initial begin
      int  zeros;
      bit  ok;
      bit  ld_pend;
      wr_t w;
      zeros = 0;
      ok = 0;
      ld_pend = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            zeros = 0;
            ok = 0;
            ld_pend = 0;
         end else begin
            if (mem_memwrite || mem_memread)
               chk("strobe_after_init", 32'(ok), 32'd1);
            if (mem_memwrite) begin
               if (wr_q.size() == 0) begin
                  chk("unexpected_write", 32'd1, 32'd0);
               end else begin
                  w = wr_q.pop_front();
                  chk("wr_addr", mem_addr, w.a);
                  chk("wr_data", mem_write_data, w.d);
                  chk("wr_mask", 32'(mem_sign_mask), 32'(w.m));
               end
            end
            if (mem_memread) begin
               chk("load_order", 32'(wr_q.size()), 32'd0);
               if (rda_q.size() == 0) begin
                  chk("unexpected_read", 32'd1, 32'd0);
               end else begin
                  chk("rd_addr", mem_addr, rda_q.pop_front());
                  chk("rd_mask", 32'(mem_sign_mask),
                      32'(rdm_q.pop_front()));
               end
            end
            if (ld_pend && !clk_stall) begin
               if (rd_q.size() == 0)
                  chk("unexpected_load_done", 32'd1, 32'd0);
               else
                  chk("read_data", read_data, rd_q.pop_front());
               ld_pend = 0;
            end
            if (!clk_stall && memread) ld_pend = 1;
            chk("count_bound", 32'(int'(wbuf_count) <= DEPTH), 32'd1);
            if (int'(wbuf_count) > peak) peak = int'(wbuf_count);
            if (!ok) begin
               if (!mem_clk_stall) zeros++;
               else zeros = 0;
               if (zeros >= 2) ok = 1;
            end
         end
      end
   end

   task automatic do_req(input bit rd, input bit wr,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic [3:0] m,
                         output int slen,
                         output int rcyc);
      wr_t w;
      addr = a;
      write_data = d;
      sign_mask = m;
      memread = rd;
      memwrite = wr;
      if (rd) begin
         rd_q.push_back(ref_rd(a));
         rda_q.push_back(a);
         rdm_q.push_back(m);
      end else if (wr) begin
         w.a = a;
         w.d = d;
         w.m = m;
         wr_q.push_back(w);
         ref_mem[a] = d;
      end
      @(posedge clk); #1;
      memread = 1'b0;
      memwrite = 1'b0;
      slen = 0;
      rcyc = 0;
      while (clk_stall && slen < 400) begin
         slen++;
         if (mem_memread && rcyc == 0) rcyc = slen;
         @(posedge clk); #1;
      end
      if (clk_stall) chk("stall_timeout", 32'd1, 32'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((wr_q.size() != 0 || mem_clk_stall || wbuf_count != 0)
             && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout", 32'(n < 3000), 32'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int sl, rc, stalls;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_read_data", read_data, 32'h0);
      chk("rst_clk_stall", 32'(clk_stall), 32'd0);
      chk("rst_count", 32'(wbuf_count), 32'd0);
      chk("rst_strobes", 32'({mem_memwrite, mem_memread}), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);

      // Preload: data_mem busy for a long time after reset.
      preload = 1'b1;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      do_req(0, 1, 32'h100, 32'hA5A5_0001, 4'b1111, sl, rc);
      chk("preload_no_stall", 32'(sl), 32'd0);
      repeat (2046) @(posedge clk);
      #1;
      chk("preload_count", 32'(wbuf_count), 32'd1);
      chk("preload_queued", 32'(wr_q.size()), 32'd1);
      preload = 1'b0;
      drain();

      // Load on an empty, idle buffer.
      lat = 2;
      mock_mem[32'h40] = 32'h1234_5678;
      ref_mem[32'h40] = 32'h1234_5678;
      do_req(1, 0, 32'h40, 32'h0, 4'b0010, sl, rc);
      chk("ld_stall_len", 32'(sl), 32'd5);
      chk("ld_read_cycle", 32'(rc), 32'd2);
      chk("ld_data", read_data, 32'h1234_5678);
      drain();

      // Store burst into a DEPTH-entry buffer.
      peak = 0;
      for (int i = 0; i < 6; i++)
         do_req(0, 1, 32'(i * 4), 32'hB000_0000 + 32'(i),
                4'b0100, sl, rc);
      drain();
      chk("burst_peak", 32'(peak), 32'(DEPTH));

      // Slow data_mem forces the full-buffer stall path.
      lat = 6;
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         do_req(0, 1, 32'h80 + 32'(i * 4), 32'hC000_0000 + 32'(i),
                4'b1111, sl, rc);
         stalls += sl;
      end
      drain();
      chk("full_stall_seen", 32'(stalls > 0), 32'd1);

      // Read after write to the same address.
      lat = 2;
      do_req(0, 1, 32'h10, 32'hDEAD_BEEF, 4'b1111, sl, rc);
      do_req(1, 0, 32'h10, 32'h0, 4'b1111, sl, rc);
      chk("raw_data", read_data, 32'hDEAD_BEEF);

      // Simultaneous request acts as a load only.
      do_req(1, 1, 32'h10, 32'h0BAD_0BAD, 4'b1111, sl, rc);
      chk("simul_count", 32'(wbuf_count), 32'd0);
      chk("simul_data", read_data, 32'hDEAD_BEEF);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 80; i++) begin
         logic [31:0] ra;
         lat = int'($urandom_range(0, 4));
         ra = 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
         if ($urandom_range(0, 9) < 6)
            do_req(0, 1, ra, $urandom, 4'($urandom), sl, rc);
         else
            do_req(1, 0, ra, 32'h0, 4'($urandom), sl, rc);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      drain();

      // Asynchronous reset with stores queued and one in flight.
      lat = 6;
      for (int i = 0; i < 4; i++)
         do_req(0, 1, 32'h300 + 32'(i * 4), 32'hE000_0000 + 32'(i),
                4'b1111, sl, rc);
      chk("pre_reset_count", 32'(wbuf_count), 32'd3);
      chk("pre_reset_busy", 32'(mem_clk_stall), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_clk_stall", 32'(clk_stall), 32'd0);
      chk("arst_count", 32'(wbuf_count), 32'd0);
      chk("arst_read_data", read_data, 32'h0);
      chk("arst_strobes", 32'({mem_memwrite, mem_memread}), 32'd0);
      chk("arst_mem_addr", mem_addr, 32'h0);
      chk("arst_mem_wdata", mem_write_data, 32'h0);
      chk("arst_mem_mask", 32'(mem_sign_mask), 32'd0);
      wr_q.delete();
      rd_q.delete();
      rda_q.delete();
      rdm_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      ref_mem = mock_mem;
      @(posedge clk); #1;
      lat = 2;
      do_req(0, 1, 32'h400, 32'h5A5A_1234, 4'b1111, sl, rc);
      do_req(1, 0, 32'h400, 32'h0, 4'b1111, sl, rc);
      chk("post_reset_data", read_data, 32'h5A5A_1234);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
